// File: rtl/thread_scheduler.sv
// thread_scheduler: switch-on-event scheduler that drains the pipeline on a miss or
// thread completion, then redirects fetch to the next runnable thread round-robin.
module thread_scheduler #(
  parameter int                    NUM_THREADS  = 2,
  parameter int                    ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_STRIDE  = 32'h8000_0000,
  parameter int                    DRAIN_CYCLES = 3,
  localparam int                   TW           = NUM_THREADS > 1 ? $clog2(NUM_THREADS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  switch_req,
  input  logic [ADDR_WIDTH-1:0] switch_pc,
  input  logic                  thread_done,
  input  logic                  resolve_valid,
  input  logic [TW-1:0]         resolve_tid,
  output logic [TW-1:0]         thread_id,
  output logic                  flush,
  output logic                  redirect_valid,
  output logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  idle,
  output logic                  all_done,
  output logic [15:0]           switch_count
);
  typedef enum logic [2:0] {RUN, DRAIN, SELECT, IDLE, HALT} state_t;
  state_t state, state_n;
  logic [3:0] cnt;
  logic [NUM_THREADS-1:0] blocked, done, res_mask, eff_blocked, blk_mask, done_mask, runnable;
  logic [ADDR_WIDTH-1:0] resume_pc [NUM_THREADS];
  logic found, go, flush_n, idle_n, all_done_n;
  logic [TW-1:0] winner;
  assign res_mask    = (resolve_valid && int'(resolve_tid) < NUM_THREADS) ? NUM_THREADS'(1) << resolve_tid : '0;
  assign blk_mask    = (state == RUN && switch_req && !thread_done) ? NUM_THREADS'(1) << thread_id : '0;
  assign done_mask   = (state == RUN && thread_done) ? NUM_THREADS'(1) << thread_id : '0;
  // a resolve landing this cycle is already visible to the selection it races with
  assign eff_blocked = blocked & ~res_mask;
  assign runnable    = ~done & ~eff_blocked;
  assign go          = found && (state == SELECT || state == IDLE);
  always_comb begin
    found  = 1'b0;
    winner = thread_id;
    for (int k = NUM_THREADS; k >= 1; k--)
      if (runnable[TW'((int'(thread_id) + k) % NUM_THREADS)]) begin
        found  = 1'b1;
        winner = TW'((int'(thread_id) + k) % NUM_THREADS);
      end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= RUN;
    else        state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      RUN:     state_n = (thread_done || switch_req) ? DRAIN : RUN;
      DRAIN:   state_n = cnt == 4'd0 ? SELECT : DRAIN;
      SELECT:  state_n = found ? RUN : (&done ? HALT : IDLE);
      IDLE:    state_n = found ? RUN : IDLE;
      default: state_n = HALT;
    endcase
  end
  always_comb begin
    flush_n    = state_n != RUN;
    idle_n     = state_n == IDLE;
    all_done_n = state_n == HALT;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      thread_id      <= '0;
      cnt            <= '0;
      blocked        <= '0;
      done           <= '0;
      flush          <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      idle           <= 1'b0;
      all_done       <= 1'b0;
      switch_count   <= '0;
      for (int i = 0; i < NUM_THREADS; i++) resume_pc[i] <= ADDR_WIDTH'(i) * BASE_STRIDE;
    end else begin
      blocked        <= eff_blocked | blk_mask;
      done           <= done | done_mask;
      cnt            <= state == DRAIN ? cnt - 4'd1 : 4'(DRAIN_CYCLES - 1);
      flush          <= flush_n;
      idle           <= idle_n;
      all_done       <= all_done_n;
      redirect_valid <= go;
      if (blk_mask != '0) resume_pc[thread_id] <= switch_pc;
      if (go) begin
        thread_id    <= winner;
        redirect_pc  <= resume_pc[winner];
        switch_count <= switch_count + {15'd0, switch_count != 16'hFFFF};
      end
    end
endmodule

// File: tb/tb_thread_scheduler.sv
// tb_thread_scheduler: directed scenarios with a per-cycle reference model of the scheduler.
module tb_thread_scheduler;
  localparam int N = 2;
  localparam int DC = 3;
  logic clk = 1'b0, rst_n = 1'b0;
  logic switch_req = 1'b0, thread_done = 1'b0, resolve_valid = 1'b0;
  logic [31:0] switch_pc = '0;
  logic [0:0] resolve_tid = '0;
  logic [0:0] thread_id;
  logic flush, redirect_valid, idle, all_done;
  logic [31:0] redirect_pc;
  logic [15:0] switch_count;
  int errors = 0, checks = 0;

  thread_scheduler #(.NUM_THREADS(N), .ADDR_WIDTH(32), .BASE_STRIDE(32'h8000_0000), .DRAIN_CYCLES(DC)) dut (
    .clk(clk), .rst_n(rst_n), .switch_req(switch_req), .switch_pc(switch_pc),
    .thread_done(thread_done), .resolve_valid(resolve_valid), .resolve_tid(resolve_tid),
    .thread_id(thread_id), .flush(flush), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .idle(idle), .all_done(all_done), .switch_count(switch_count));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Reference model: thread tables plus "edges until decision" and waiting/halted flags
  int m_tid, m_wait, m_cnt;
  bit m_idle, m_halt, m_rv;
  logic [31:0] m_rpc;
  bit m_blk [N];
  bit m_dn [N];
  logic [31:0] m_pc [N];

  function automatic bit pick(output int w);
    w = 0;
    for (int k = 1; k <= N; k++) begin
      int c = (m_tid + k) % N;
      if (!m_dn[c] && !m_blk[c]) begin w = c; return 1'b1; end
    end
    return 1'b0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_tid = 0; m_wait = 0; m_cnt = 0; m_idle = 0; m_halt = 0; m_rv = 0; m_rpc = '0;
      for (int i = 0; i < N; i++) begin m_blk[i] = 0; m_dn[i] = 0; m_pc[i] = 32'(i) * 32'h8000_0000; end
    end else begin
      int w;
      bit all;
      m_rv = 0;
      if (resolve_valid && int'(resolve_tid) < N) m_blk[resolve_tid] = 0;
      if (!(m_wait > 0 || m_idle || m_halt)) begin
        if (thread_done) begin m_dn[m_tid] = 1; m_wait = DC + 1; end
        else if (switch_req) begin m_blk[m_tid] = 1; m_pc[m_tid] = switch_pc; m_wait = DC + 1; end
      end else if (m_wait > 1) m_wait--;
      else if (m_wait == 1 || m_idle) begin
        m_wait = 0;
        if (pick(w)) begin
          m_tid = w; m_rv = 1; m_rpc = m_pc[w]; m_idle = 0;
          if (m_cnt < 16'hFFFF) m_cnt++;
        end else begin
          all = 1;
          for (int i = 0; i < N; i++) all &= m_dn[i];
          if (all) m_halt = 1; else m_idle = 1;
        end
      end
    end
  end

  always @(negedge clk) if (rst_n) begin
    chk("thread_id", 32'(thread_id), 32'(m_tid));
    chk("flush", 32'(flush), 32'(m_wait > 0 || m_idle || m_halt));
    chk("redirect_valid", 32'(redirect_valid), 32'(m_rv));
    chk("redirect_pc", redirect_pc, m_rpc);
    chk("idle", 32'(idle), 32'(m_idle));
    chk("all_done", 32'(all_done), 32'(m_halt));
    chk("switch_count", 32'(switch_count), 32'(m_cnt));
  end

  task automatic ev(input bit sw, input bit dn, input logic [31:0] pc);
    switch_req = sw; thread_done = dn; switch_pc = pc;
    @(negedge clk);
    switch_req = 0; thread_done = 0;
  endtask

  task automatic resolve(input int t);
    resolve_valid = 1; resolve_tid = 1'(t);
    @(negedge clk);
    resolve_valid = 0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("rst_tid", 32'(thread_id), 0);
    chk("rst_flush", 32'(flush), 0);
    chk("rst_all_done", 32'(all_done), 0);
    chk("rst_count", 32'(switch_count), 0);
    // thread 0 misses: flush through drain, redirect to thread 1 base
    ev(1, 0, 32'h0000_0040);
    chk("sw1_flush", 32'(flush), 1);
    repeat (3) @(negedge clk);
    chk("sw1_select_rv", 32'(redirect_valid), 0);
    @(negedge clk);
    chk("sw1_rv", 32'(redirect_valid), 1);
    chk("sw1_pc", redirect_pc, 32'h8000_0000);
    chk("sw1_tid", 32'(thread_id), 1);
    chk("sw1_flush_off", 32'(flush), 0);
    resolve(0);
    ev(1, 0, 32'h8000_0100);
    repeat (4) @(negedge clk);
    chk("sw2_pc", redirect_pc, 32'h0000_0040);
    chk("sw2_count", 32'(switch_count), 2);
    chk("sw2_tid", 32'(thread_id), 0);
    // both threads blocked -> idle until thread 1 resolves
    ev(1, 0, 32'h0000_0044);
    repeat (4) @(negedge clk);
    chk("idle_on", 32'(idle), 1);
    chk("idle_flush", 32'(flush), 1);
    repeat (2) @(negedge clk);
    resolve(1);
    chk("idle_rv", 32'(redirect_valid), 1);
    chk("idle_pc", redirect_pc, 32'h8000_0100);
    chk("idle_off", 32'(idle), 0);
    resolve(0);
    ev(1, 0, 32'h8000_0200);
    repeat (4) @(negedge clk);
    chk("back0_pc", redirect_pc, 32'h0000_0044);
    resolve(1);
    // block and resolve of thread 0 on the same edge: block wins
    switch_req = 1; switch_pc = 32'h0000_0048; resolve_valid = 1; resolve_tid = 0;
    @(negedge clk);
    switch_req = 0; resolve_valid = 0;
    repeat (4) @(negedge clk);
    chk("same_tid", 32'(thread_id), 1);
    chk("same_pc", redirect_pc, 32'h8000_0200);
    ev(1, 0, 32'h8000_0300);
    repeat (4) @(negedge clk);
    chk("same_idle", 32'(idle), 1);
    resolve(0);
    chk("same_pc2", redirect_pc, 32'h0000_0048);
    chk("same_count", 32'(switch_count), 6);
    // done beats switch; resolve during drain is seen by select
    ev(1, 1, 32'hDEAD_0000);
    resolve(1);
    repeat (3) @(negedge clk);
    chk("prio_tid", 32'(thread_id), 1);
    chk("prio_pc", redirect_pc, 32'h8000_0300);
    ev(0, 1, 32'h0);
    repeat (4) @(negedge clk);
    chk("halt_all_done", 32'(all_done), 1);
    chk("halt_flush", 32'(flush), 1);
    repeat (6) begin
      @(negedge clk);
      chk("halt_rv", 32'(redirect_valid), 0);
    end
    // async reset in the middle of drain
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    ev(1, 0, 32'h0000_0050);
    @(posedge clk);
    #2;
    chk("ar_pre_flush", 32'(flush), 1);
    rst_n = 0;
    #1;
    chk("ar_flush", 32'(flush), 0);
    chk("ar_tid", 32'(thread_id), 0);
    chk("ar_count", 32'(switch_count), 0);
    chk("ar_rv", 32'(redirect_valid), 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("ar_after_rv", 32'(redirect_valid), 0);
    chk("ar_after_pc", redirect_pc, 32'h0000_0000);
    ev(1, 0, 32'h0000_0060);
    repeat (4) @(negedge clk);
    chk("ar_sw_pc", redirect_pc, 32'h8000_0000);
    chk("ar_sw_count", 32'(switch_count), 1);
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
